// File: rtl/n8_pkg.sv
// Shared definitions for the 8-button serial pad protocol (driver and responder).
package n8_pkg;

  localparam int NUM_BUTTONS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } n8_resp_state_t;

  // The wire is active-low: a pressed button pulls the data line to 0.
  function automatic logic pressed_to_line(input logic pressed);
    return ~pressed;
  endfunction

endpackage

// File: rtl/n8_responder_if.sv
// Host-facing serial pad wires: latch and shift clock from the host, data back.
interface n8_responder_if;
  logic latch_in;
  logic pulse_in;
  logic data_out;

  modport master (output latch_in, output pulse_in, input data_out);
  modport slave  (input latch_in, input pulse_in, output data_out);
endinterface

// File: rtl/n8_sync_edge.sv
// Two-flop synchroniser for an asynchronous host line, with rise/fall detect.
module n8_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  // p0/p1: metastability chain; p2: previous synchronised level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= async_in;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign rise = sync_p1 & ~prev_p2;
  assign fall = ~sync_p1 & prev_p2;

endmodule

// File: rtl/n8_responder.sv
// Emulates the pad's parallel-in/serial-out shift register toward an external host.
module n8_responder
  import n8_pkg::*;
#(
  parameter int   TIMEOUT_CYCLES = 50000,
  parameter logic FILL_BIT       = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons,
  n8_responder_if.slave          host,
  output logic                   active,
  output logic                   frame_done,
  output logic                   overrun,
  output logic                   timeout
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST_IDX = 4'(NUM_BUTTONS);

  logic latch_rise, latch_fall;
  logic pulse_rise, pulse_fall_unused;

  n8_sync_edge u_latch_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (host.latch_in),
    .rise     (latch_rise),
    .fall     (latch_fall)
  );

  n8_sync_edge u_pulse_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (host.pulse_in),
    .rise     (pulse_rise),
    .fall     (pulse_fall_unused)
  );

  n8_resp_state_t         state, state_d;
  logic [NUM_BUTTONS-1:0] shreg, shreg_d;
  logic [3:0]             bit_idx, bit_idx_d;
  logic [TMR_W-1:0]       timer, timer_d;
  logic                   data_q, data_d;
  logic                   frame_done_d, overrun_d, timeout_d;

  always_comb begin
    state_d      = state;
    shreg_d      = shreg;
    bit_idx_d    = bit_idx;
    timer_d      = timer;
    data_d       = data_q;
    frame_done_d = 1'b0;
    overrun_d    = 1'b0;
    timeout_d    = 1'b0;

    case (state)
      IDLE: begin
        if (latch_rise) begin
          state_d = LOAD;
          shreg_d = buttons;
          data_d  = pressed_to_line(buttons[BTN_A]);
        end
      end

      LOAD: begin
        shreg_d = buttons;
        data_d  = pressed_to_line(buttons[BTN_A]);
        if (latch_fall) begin
          bit_idx_d = 4'd0;
          timer_d   = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        // Priority: a new latch beats a shift, a shift beats the timeout.
        if (latch_rise) begin
          overrun_d = 1'b1;
          state_d   = LOAD;
          shreg_d   = buttons;
          data_d    = pressed_to_line(buttons[BTN_A]);
        end else if (pulse_rise) begin
          bit_idx_d = bit_idx + 4'd1;
          shreg_d   = {1'b0, shreg[NUM_BUTTONS-1:1]};
          timer_d   = '0;
          if (bit_idx_d == LAST_IDX) begin
            data_d       = FILL_BIT;
            frame_done_d = 1'b1;
            state_d      = DONE;
          end else begin
            data_d = pressed_to_line(shreg[1]);
          end
        end else if (timer == TMR_LAST) begin
          timeout_d = 1'b1;
          data_d    = FILL_BIT;
          state_d   = IDLE;
        end else if (timer != '1) begin
          timer_d = timer + TMR_W'(1);
        end
      end

      DONE: begin
        data_d = FILL_BIT;
        if (latch_rise) begin
          state_d = LOAD;
          shreg_d = buttons;
          data_d  = pressed_to_line(buttons[BTN_A]);
        end
      end

      default: begin
        state_d = IDLE;
        data_d  = FILL_BIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_idx    <= 4'd0;
      timer      <= '0;
      data_q     <= FILL_BIT;
      active     <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_d;
      shreg      <= shreg_d;
      bit_idx    <= bit_idx_d;
      timer      <= timer_d;
      data_q     <= data_d;
      active     <= (state_d == LOAD) || (state_d == SHIFT);
      frame_done <= frame_done_d;
      overrun    <= overrun_d;
      timeout    <= timeout_d;
    end
  end

  assign host.data_out = data_q;

endmodule
